int_ctrl: RTL

//  Machine external-interrupt controller sitting directly upstream of the CSR unit.

---
 rtl/int_ctrl_pkg.sv | 20 ++
 rtl/int_ctrl_if.sv | 30 +++
 rtl/int_ctrl_irq_sync.sv | 43 ++++
 rtl/int_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the machine external-interrupt controller.
package int_ctrl_pkg;

    typedef enum logic {
        INT_IDLE    = 1'b0,
        INT_SERVICE = 1'b1
    } int_state_e;

    localparam int unsigned     INT_NUM_SRC     = 4;
    localparam int unsigned     INT_SYNC_STAGES = 2;
    localparam logic [3:0]      INT_EDGE_MASK   = 4'b0011;
    // Position of MEIP inside mip; the CSR unit places meip_o here.
    localparam int unsigned     MEIP_BIT        = 11;

    // Width of a source ID, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-side bundle of the interrupt controller: IRQ lines, CSR gating and trap outputs.
interface int_ctrl_if
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = INT_NUM_SRC
);
    localparam int unsigned ID_W = id_width(NUM_SRC);

    logic [NUM_SRC-1:0] irq_i;
    logic [NUM_SRC-1:0] src_en_i;
    logic               mstatus_mie_i;
    logic               mie_meie_i;
    logic               pipe_ok_i;
    logic               mret_i;
    logic               meip_o;
    logic               int_taken_o;
    logic [ID_W-1:0]    int_id_o;
    logic               in_service_o;

    modport master (
        output irq_i, src_en_i, mstatus_mie_i, mie_meie_i, pipe_ok_i, mret_i,
        input  meip_o, int_taken_o, int_id_o, in_service_o
    );

    modport slave (
        input  irq_i, src_en_i, mstatus_mie_i, mie_meie_i, pipe_ok_i, mret_i,
        output meip_o, int_taken_o, int_id_o, in_service_o
    );

endinterface

// File: rtl/int_ctrl_irq_sync.sv
// One IRQ line: multi-flop synchroniser, plus a rise detector for edge-triggered lines.
module int_ctrl_irq_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic req
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    // Shift the asynchronous line through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    if (EDGE) begin : g_edge
        logic s_d_q;

        // Delayed copy of the synchronised level for rise detection.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_d_q <= 1'b0;
            end else begin
                s_d_q <= s;
            end
        end

        assign req = s & ~s_d_q;
    end else begin : g_level
        assign req = s;
    end

endmodule

// File: rtl/int_ctrl.sv
// Machine external-interrupt controller: pending capture, fixed priority, take/service FSM.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned        NUM_SRC     = INT_NUM_SRC,
    parameter int unsigned        SYNC_STAGES = INT_SYNC_STAGES,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = NUM_SRC'(INT_EDGE_MASK)
) (
    input  logic      clk,
    input  logic      rst,
    int_ctrl_if.slave bus
);

    localparam int unsigned ID_W = id_width(NUM_SRC);

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] elig;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    id_q;
    logic               take_c;
    int_state_e         state_q;
    int_state_e         state_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        int_ctrl_irq_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE        (EDGE_MASK[i])
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .irq (bus.irq_i[i]),
            .req (req[i])
        );

        if (EDGE_MASK[i]) begin : g_edge
            logic pend_q;

            // Edge pending: a new rise beats the clear from a same-cycle take.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_q <= 1'b0;
                end else if (req[i]) begin
                    pend_q <= 1'b1;
                end else if (take_c && (sel == ID_W'(i))) begin
                    pend_q <= 1'b0;
                end
            end

            assign pend[i] = pend_q;
        end else begin : g_level
            assign pend[i] = req[i];
        end
    end

    assign elig = pend & bus.src_en_i;

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        sel = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    // Trap state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and take pulse; only IDLE can take, so traps never nest.
    always_comb begin
        state_d = state_q;
        take_c  = 1'b0;
        case (state_q)
            INT_IDLE: begin
                if ((|elig) && bus.mstatus_mie_i && bus.mie_meie_i && bus.pipe_ok_i) begin
                    take_c  = 1'b1;
                    state_d = INT_SERVICE;
                end
            end
            INT_SERVICE: begin
                if (bus.mret_i && bus.pipe_ok_i) begin
                    state_d = INT_IDLE;
                end
            end
            default: state_d = INT_IDLE;
        endcase
    end

    // Capture the taken source ID and hold it through service.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q <= '0;
        end else if (take_c) begin
            id_q <= sel;
        end
    end

    assign bus.meip_o       = |elig;
    assign bus.int_taken_o  = take_c;
    assign bus.int_id_o     = id_q;
    assign bus.in_service_o = (state_q == INT_SERVICE);

endmodule
